// File: rtl/noise_envelope.sv
// Gate-triggered ADSR envelope applied to a 1-bit LFSR noise stream.
// Steps are paced by a shared sample-rate tick through a per-phase rate divider.
module noise_envelope #(
  parameter int AMP_W  = 4,
  parameter int RATE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              gate,
  input  logic              noise_in,
  input  logic [RATE_W-1:0] attack_rate,
  input  logic [RATE_W-1:0] decay_rate,
  input  logic [AMP_W-1:0]  sustain_level,
  input  logic [RATE_W-1:0] release_rate,
  output logic [AMP_W-1:0]  amp_out,
  output logic [AMP_W-1:0]  env_level,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam logic [AMP_W-1:0] MAX = '1;

  state_t            state, state_n;
  logic [AMP_W-1:0]  env, env_n;
  logic [RATE_W-1:0] div, div_n, cur_rate;
  logic              gate_q, rise, fall, step;

  assign rise = gate & ~gate_q;
  assign fall = ~gate & gate_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      env     <= '0;
      div     <= '0;
      gate_q  <= 1'b0;
      amp_out <= '0;
    end else begin
      state   <= state_n;
      env     <= env_n;
      div     <= div_n;
      gate_q  <= gate;
      amp_out <= noise_in ? env : '0;
    end
  end

  // Gate events take priority over a coincident tick and restart the divider.
  always_comb begin
    state_n  = state;
    env_n    = env;
    div_n    = div;
    step     = 1'b0;
    cur_rate = '0;

    case (state)
      ATTACK:  cur_rate = attack_rate;
      DECAY:   cur_rate = decay_rate;
      RELEASE: cur_rate = release_rate;
      default: cur_rate = '0;
    endcase

    if (rise) begin
      state_n = ATTACK;
      div_n   = '0;
    end else if (fall && (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
      state_n = RELEASE;
      div_n   = '0;
    end else if (state != IDLE && tick) begin
      if (div == cur_rate) begin
        div_n = '0;
        step  = 1'b1;
      end else begin
        div_n = div + 1'b1;
      end
    end

    // Every saturation check below keeps env from wrapping at 0 or MAX.
    if (step) begin
      case (state)
        ATTACK: begin
          if (env != MAX) env_n = env + 1'b1;
          if (env_n == MAX) state_n = (sustain_level == MAX) ? SUSTAIN : DECAY;
        end
        DECAY: begin
          if (env <= sustain_level) begin
            state_n = SUSTAIN;
          end else begin
            env_n = env - 1'b1;
            if (env_n == sustain_level) state_n = SUSTAIN;
          end
        end
        RELEASE: begin
          if (env == '0) begin
            state_n = IDLE;
          end else begin
            env_n = env - 1'b1;
            if (env_n == '0) state_n = IDLE;
          end
        end
        default: env_n = env;
      endcase
    end
  end

  assign env_level = env;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_noise_envelope.sv
// Directed self-checking bench for noise_envelope with hand-computed envelope values.
module tb_noise_envelope;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       gate;
  logic       noise_in;
  logic [7:0] attack_rate;
  logic [7:0] decay_rate;
  logic [3:0] sustain_level;
  logic [7:0] release_rate;
  logic [3:0] amp_out;
  logic [3:0] env_level;
  logic       busy;

  int checks = 0;
  int errors = 0;

  noise_envelope #(.AMP_W(4), .RATE_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick          (tick),
    .gate          (gate),
    .noise_in      (noise_in),
    .attack_rate   (attack_rate),
    .decay_rate    (decay_rate),
    .sustain_level (sustain_level),
    .release_rate  (release_rate),
    .amp_out       (amp_out),
    .env_level     (env_level),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    gate  = 1'b0;
    tick  = 1'b0;
    #2;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    cyc();
    cyc();
    checks++; if (env_level !== 4'd0) begin errors++; $display("[TB] FAIL reset_env: got %0d expected 0", env_level); end
    checks++; if (amp_out !== 4'd0) begin errors++; $display("[TB] FAIL reset_amp: got %0d expected 0", amp_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    rst_n = 1'b1;
    attack_rate = 8'd0;
    tick = 1'b1;
    noise_in = 1'b1;
    cyc();
    gate = 1'b1;
    repeat (8) cyc();
    checks++; if (env_level !== 4'd7) begin errors++; $display("[TB] FAIL pre_reset_env: got %0d expected 7", env_level); end
    rst_n = 1'b0;
    #1;
    checks++; if (env_level !== 4'd0) begin errors++; $display("[TB] FAIL async_env: got %0d expected 0", env_level); end
    checks++; if (amp_out !== 4'd0) begin errors++; $display("[TB] FAIL async_amp: got %0d expected 0", amp_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL async_busy: got %0b expected 0", busy); end
    gate = 1'b0;
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_idle: got %0b expected 0", busy); end
    checks++; if (env_level !== 4'd0) begin errors++; $display("[TB] FAIL post_reset_env: got %0d expected 0", env_level); end
    gate = 1'b1;
    cyc();
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rise_after_reset: got %0b expected 1", busy); end
  endtask

  task automatic test_full_adsr();
    int exp_env;
    int prev_env;
    apply_reset();
    attack_rate = 8'd0; decay_rate = 8'd1; sustain_level = 4'd10; release_rate = 8'd3;
    noise_in = 1'b1; tick = 1'b1;
    gate = 1'b1;
    cyc();
    checks++; if (env_level !== 4'd0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL adsr_start: got env %0d busy %0b expected 0 1", env_level, busy); end
    prev_env = 0;
    for (int i = 1; i <= 15; i++) begin
      cyc();
      exp_env = i;
      checks++; if (env_level !== exp_env[3:0]) begin errors++; $display("[TB] FAIL attack_env[%0d]: got %0d expected %0d", i, env_level, exp_env); end
      checks++; if (amp_out !== prev_env[3:0]) begin errors++; $display("[TB] FAIL attack_amp[%0d]: got %0d expected %0d", i, amp_out, prev_env); end
      prev_env = exp_env;
    end
    for (int j = 1; j <= 15; j++) begin
      cyc();
      exp_env = (j <= 10) ? 15 - j / 2 : 10;
      checks++; if (env_level !== exp_env[3:0]) begin errors++; $display("[TB] FAIL decay_env[%0d]: got %0d expected %0d", j, env_level, exp_env); end
      checks++; if (amp_out !== prev_env[3:0]) begin errors++; $display("[TB] FAIL decay_amp[%0d]: got %0d expected %0d", j, amp_out, prev_env); end
      prev_env = exp_env;
    end
    gate = 1'b0;
    cyc();
    checks++; if (env_level !== 4'd10 || busy !== 1'b1) begin errors++; $display("[TB] FAIL release_start: got env %0d busy %0b expected 10 1", env_level, busy); end
    prev_env = 10;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      exp_env = 10 - k / 4;
      checks++; if (env_level !== exp_env[3:0]) begin errors++; $display("[TB] FAIL release_env[%0d]: got %0d expected %0d", k, env_level, exp_env); end
      checks++; if (amp_out !== prev_env[3:0]) begin errors++; $display("[TB] FAIL release_amp[%0d]: got %0d expected %0d", k, amp_out, prev_env); end
      checks++; if (busy !== (k < 40)) begin errors++; $display("[TB] FAIL release_busy[%0d]: got %0b expected %0b", k, busy, (k < 40)); end
      prev_env = exp_env;
    end
    cyc();
    checks++; if (busy !== 1'b0 || env_level !== 4'd0) begin errors++; $display("[TB] FAIL adsr_idle: got env %0d busy %0b expected 0 0", env_level, busy); end
  endtask

  task automatic test_sustain_max();
    apply_reset();
    attack_rate = 8'd0; decay_rate = 8'd0; sustain_level = 4'd15; tick = 1'b1;
    gate = 1'b1;
    cyc();
    repeat (15) cyc();
    checks++; if (env_level !== 4'd15) begin errors++; $display("[TB] FAIL smax_peak: got %0d expected 15", env_level); end
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++; if (env_level !== 4'd15 || busy !== 1'b1) begin errors++; $display("[TB] FAIL smax_hold[%0d]: got env %0d busy %0b expected 15 1", i, env_level, busy); end
    end
  endtask

  task automatic test_retrigger();
    apply_reset();
    attack_rate = 8'd0; release_rate = 8'd0; sustain_level = 4'd10; tick = 1'b1;
    gate = 1'b1;
    cyc();
    repeat (5) cyc();
    checks++; if (env_level !== 4'd5) begin errors++; $display("[TB] FAIL early_peak: got %0d expected 5", env_level); end
    gate = 1'b0;
    cyc();
    checks++; if (env_level !== 4'd5 || busy !== 1'b1) begin errors++; $display("[TB] FAIL early_release: got env %0d busy %0b expected 5 1", env_level, busy); end
    cyc();
    checks++; if (env_level !== 4'd4) begin errors++; $display("[TB] FAIL release_step1: got %0d expected 4", env_level); end
    cyc();
    checks++; if (env_level !== 4'd3) begin errors++; $display("[TB] FAIL release_step2: got %0d expected 3", env_level); end
    gate = 1'b1;
    cyc();
    checks++; if (env_level !== 4'd3) begin errors++; $display("[TB] FAIL retrig_hold: got %0d expected 3", env_level); end
    cyc();
    checks++; if (env_level !== 4'd4) begin errors++; $display("[TB] FAIL retrig_up1: got %0d expected 4", env_level); end
    cyc();
    checks++; if (env_level !== 4'd5) begin errors++; $display("[TB] FAIL retrig_up2: got %0d expected 5", env_level); end
  endtask

  task automatic test_collision();
    apply_reset();
    attack_rate = 8'd1; decay_rate = 8'd0; release_rate = 8'd1; sustain_level = 4'd0; tick = 1'b1;
    gate = 1'b1;
    cyc();
    repeat (18) cyc();
    checks++; if (env_level !== 4'd9) begin errors++; $display("[TB] FAIL coll_pre: got %0d expected 9", env_level); end
    cyc();
    checks++; if (env_level !== 4'd9) begin errors++; $display("[TB] FAIL coll_div: got %0d expected 9", env_level); end
    gate = 1'b0;
    cyc();
    checks++; if (env_level !== 4'd9 || busy !== 1'b1) begin errors++; $display("[TB] FAIL coll_edge: got env %0d busy %0b expected 9 1", env_level, busy); end
    cyc();
    checks++; if (env_level !== 4'd9) begin errors++; $display("[TB] FAIL coll_divclr: got %0d expected 9", env_level); end
    cyc();
    checks++; if (env_level !== 4'd8) begin errors++; $display("[TB] FAIL coll_release: got %0d expected 8", env_level); end
  endtask

  task automatic test_noise_gating();
    apply_reset();
    attack_rate = 8'd0; decay_rate = 8'd0; sustain_level = 4'd12; release_rate = 8'd0;
    tick = 1'b1; noise_in = 1'b1;
    gate = 1'b1;
    cyc();
    repeat (25) cyc();
    checks++; if (env_level !== 4'd12) begin errors++; $display("[TB] FAIL noise_env: got %0d expected 12", env_level); end
    checks++; if (amp_out !== 4'd12) begin errors++; $display("[TB] FAIL noise_amp1: got %0d expected 12", amp_out); end
    noise_in = 1'b0;
    #1;
    checks++; if (amp_out !== 4'd12) begin errors++; $display("[TB] FAIL noise_latency: got %0d expected 12", amp_out); end
    cyc();
    checks++; if (amp_out !== 4'd0) begin errors++; $display("[TB] FAIL noise_amp0: got %0d expected 0", amp_out); end
    noise_in = 1'b1;
    cyc();
    checks++; if (amp_out !== 4'd12) begin errors++; $display("[TB] FAIL noise_amp2: got %0d expected 12", amp_out); end
    tick = 1'b0;
    gate = 1'b0;
    cyc();
    checks++; if (env_level !== 4'd12 || busy !== 1'b1) begin errors++; $display("[TB] FAIL notick_fall: got env %0d busy %0b expected 12 1", env_level, busy); end
    repeat (10) cyc();
    checks++; if (env_level !== 4'd12) begin errors++; $display("[TB] FAIL notick_hold: got %0d expected 12", env_level); end
    tick = 1'b1;
    cyc();
    checks++; if (env_level !== 4'd11) begin errors++; $display("[TB] FAIL tick_resume: got %0d expected 11", env_level); end
  endtask

  initial begin
    rst_n = 1'b0;
    tick = 1'b0;
    gate = 1'b0;
    noise_in = 1'b0;
    attack_rate = 8'd0;
    decay_rate = 8'd0;
    sustain_level = 4'd0;
    release_rate = 8'd0;
    test_reset();
    test_full_adsr();
    test_sustain_max();
    test_retrigger();
    test_collision();
    test_noise_gating();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/noise_envelope.md
Name: noise_envelope

Overview:
- Downstream consumer of the LFSR noise bit.
- Applies a gate-triggered attack/decay/sustain/release (ADSR) amplitude envelope to the 1-bit noise and produces a multi-bit amplitude sample for the channel mixer.
- Envelope steps are paced by a shared sample-rate strobe, with per-phase programmable rate dividers.
- Sits between the noise generator and the mixer/DAC stage.

Parameters:
- AMP_W, 4, width of the envelope level and amplitude output; maximum level MAX = 2^AMP_W-1.
- RATE_W, 8, width of the rate inputs and of the internal tick divider.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- tick  in  1  sample-rate strobe, one clk wide; all envelope timing counts ticks.
- gate  in  1  note gate; a rising edge triggers or retriggers, low releases.
- noise_in  in  1  noise bit from the LFSR.
- attack_rate  in  RATE_W  ticks per attack step, minus 1.
- decay_rate  in  RATE_W  ticks per decay step, minus 1.
- sustain_level  in  AMP_W  level held during sustain.
- release_rate  in  RATE_W  ticks per release step, minus 1.
- amp_out  out  AMP_W  registered output: noise_in ? env : 0.
- env_level  out  AMP_W  current envelope level.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, env=0, div=0, gate_q=0, amp_out=0, env_level=0, busy=0.
  - Takes effect immediately mid-envelope; no step completes on the release edge of reset.
- Gate edge detection: gate_q registers gate every clk. rise = gate & ~gate_q; fall = ~gate & gate_q.
- Divider, in every non-IDLE state:
  - On tick: if div == rate of the current phase, then div<=0 and a step occurs; else div<=div+1.
  - rate=0 steps on every tick; rate=N steps every N+1 ticks.
  - div clears to 0 on every state change.
  - Rate inputs are sampled live; a change takes effect at the next compare.
- States and transitions:
  - IDLE: env holds 0. rise -> ATTACK.
  - ATTACK: each step env<=env+1. The step that reaches MAX moves to SUSTAIN if sustain_level==MAX, else to DECAY.
  - DECAY: each step:
    - if env<=sustain_level -> SUSTAIN with env unchanged;
    - else env<=env-1, and if env-1==sustain_level -> SUSTAIN.
  - SUSTAIN: env held. Later sustain_level changes are not tracked.
  - RELEASE: each step:
    - if env==0 -> IDLE;
    - else env<=env-1, and if the result is 0 -> IDLE.
  - fall in ATTACK, DECAY or SUSTAIN -> RELEASE, env unchanged.
  - rise in any state, including RELEASE and ATTACK -> ATTACK, continuing from the current env. There is no reset to 0 (no click).
- Simultaneous events: a gate event (rise/fall) and tick in the same clk -> the gate event wins, div clears, and no step occurs that cycle.
- Output:
  - amp_out is registered one clk after env/noise_in: amp_out <= noise_in ? env : 0, updated every clk regardless of tick.
  - env_level and busy are driven directly from registers.
- Arithmetic: env is unsigned AMP_W wide and never wraps; the saturation checks above guarantee it.
- Gate low in IDLE, or rise while gate already high: no effect.

Test Plan:
- Reset: rst_n=0 mid-attack at env=7 -> amp_out, env_level and busy read 0 immediately (async). After release, the FSM stays in IDLE until the next gate rise.
- Full ADSR: tick every clk, attack_rate=0, decay_rate=1, sustain_level=10, release_rate=3, noise_in=1.
  - Gate rise -> env reaches 15 after 15 ticks.
  - env reaches 10 after 10 further ticks, then holds.
  - Gate fall -> env reaches 0 after 40 ticks, then busy=0.
  - amp_out equals env delayed by 1 clk throughout.
- Sustain at max: sustain_level=15 -> ATTACK goes directly to SUSTAIN at env=15, with no DECAY step.
- Early release and retrigger: gate falls at env=5 in ATTACK -> RELEASE from 5. Gate rises at env=3 -> ATTACK resumes from 3, not 0.
- Collision: gate fall on the same clk as the tick that would step env 9->10 -> env stays 9, state=RELEASE, div=0.
- Noise gating: env held at 12, noise_in toggling 1,0,1 -> amp_out 12,0,12, each one clk later. A tick-free period leaves env unchanged.
